// File: rtl/myrv_pkg.sv
// Shared types and constants for the RV32I decode stage: control-field enums,
// opcode/funct7 constants and the packed decoded-entry record.
package myrv_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_AND = 2'd1,
      ALU_XOR = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      ALU2_SHL = 2'd0,
      ALU2_SLT = 2'd1,
      ALU2_SHR = 2'd2,
      ALU2_IMM = 2'd3
   } alu2_op_e;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_LINK = 2'd1,
      WB_ALU  = 2'd2,
      WB_ALU2 = 2'd3
   } wb_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE   = 7'h00;
   localparam logic [6:0] F7_ALT    = 7'h20;
   localparam logic [6:0] F7_MULDIV = 7'h01;

   // funct3 010 is unused by BRANCH, so jumps reuse it as "always taken"
   localparam logic [2:0] CMP_ALWAYS = 3'b010;

   typedef struct packed {
      alu_op_e    alu_op;
      alu2_op_e   alu2_op;
      logic       alt_op;
      logic       alt2_op;
      logic [4:0] ra;
      logic [4:0] rb;
      logic [4:0] rd;
      logic       sel_pc_a;
      logic       sel_imm_b;
      wb_e        wb;
      logic       mem_read;
      logic       mem;
      logic       branch;
      logic [2:0] comparison;
      logic       muldiv;
      logic [2:0] funct3;
      logic       illegal;
   } decoded_t;

   function automatic logic [31:0] reg_mask(input logic [4:0] r);
      reg_mask = 32'd1 << r;
   endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I (+ optional RV32M) decoder producing one decoded_t.
module rv_decode_comb
   import myrv_pkg::*;
#(
   parameter bit ENABLE_M = 1'b0
) (
   input  logic [31:0] instr,
   output decoded_t    dec
);

   logic [6:0] opcode_s;
   logic [6:0] funct7_s;
   logic [2:0] funct3_s;
   logic [4:0] rs1_s;
   logic [4:0] rs2_s;
   logic [4:0] rd_s;
   logic       is_op_s;
   logic       known_s;
   logic       illegal_s;
   decoded_t   raw_s;

   assign opcode_s = instr[6:0];
   assign rd_s     = instr[11:7];
   assign funct3_s = instr[14:12];
   assign rs1_s    = instr[19:15];
   assign rs2_s    = instr[24:20];
   assign funct7_s = instr[31:25];
   assign is_op_s  = (opcode_s == OPC_OP);

   // per-opcode control, before the illegal and rd=x0 overrides
   always_comb begin
      raw_s        = '0;
      raw_s.rd     = rd_s;
      raw_s.funct3 = funct3_s;
      known_s      = 1'b1;
      case (opcode_s)
         OPC_LUI: begin
            raw_s.alu2_op   = ALU2_IMM;
            raw_s.sel_imm_b = 1'b1;
            raw_s.wb        = WB_ALU2;
         end
         OPC_AUIPC: begin
            raw_s.sel_pc_a  = 1'b1;
            raw_s.sel_imm_b = 1'b1;
            raw_s.wb        = WB_ALU;
         end
         OPC_JAL: begin
            raw_s.sel_pc_a   = 1'b1;
            raw_s.sel_imm_b  = 1'b1;
            raw_s.wb         = WB_LINK;
            raw_s.branch     = 1'b1;
            raw_s.comparison = CMP_ALWAYS;
         end
         OPC_JALR: begin
            raw_s.ra         = rs1_s;
            raw_s.sel_imm_b  = 1'b1;
            raw_s.wb         = WB_LINK;
            raw_s.branch     = 1'b1;
            raw_s.comparison = CMP_ALWAYS;
         end
         OPC_BRANCH: begin
            raw_s.ra         = rs1_s;
            raw_s.rb         = rs2_s;
            raw_s.branch     = 1'b1;
            raw_s.comparison = funct3_s;
         end
         // load data returns through the load_done path, not through wb
         OPC_LOAD: begin
            raw_s.ra        = rs1_s;
            raw_s.sel_imm_b = 1'b1;
            raw_s.mem       = 1'b1;
            raw_s.mem_read  = 1'b1;
         end
         OPC_STORE: begin
            raw_s.ra        = rs1_s;
            raw_s.rb        = rs2_s;
            raw_s.sel_imm_b = 1'b1;
            raw_s.mem       = 1'b1;
         end
         OPC_OPIMM, OPC_OP: begin
            raw_s.ra = rs1_s;
            if (is_op_s) begin
               raw_s.rb = rs2_s;
            end else begin
               raw_s.sel_imm_b = 1'b1;
            end
            case (funct3_s)
               3'b000: begin
                  raw_s.alu_op = ALU_ADD;
                  raw_s.alt_op = is_op_s & funct7_s[5];
                  raw_s.wb     = WB_ALU;
               end
               3'b001: begin raw_s.alu2_op = ALU2_SHL; raw_s.wb = WB_ALU2; end
               3'b010: begin raw_s.alu2_op = ALU2_SLT; raw_s.wb = WB_ALU2; end
               3'b011: begin
                  raw_s.alu2_op = ALU2_SLT;
                  raw_s.alt2_op = 1'b1;
                  raw_s.wb      = WB_ALU2;
               end
               3'b100: begin raw_s.alu_op = ALU_XOR; raw_s.wb = WB_ALU; end
               3'b101: begin
                  raw_s.alu2_op = ALU2_SHR;
                  raw_s.alt_op  = funct7_s[5];
                  raw_s.wb      = WB_ALU2;
               end
               3'b110: begin raw_s.alu_op = ALU_OR;  raw_s.wb = WB_ALU; end
               3'b111: begin raw_s.alu_op = ALU_AND; raw_s.wb = WB_ALU; end
               default: raw_s.wb = WB_NONE;
            endcase
            if (is_op_s && (funct7_s == F7_MULDIV)) begin
               raw_s.muldiv  = 1'b1;
               raw_s.alu_op  = ALU_ADD;
               raw_s.alu2_op = ALU2_SHL;
               raw_s.alt_op  = 1'b0;
               raw_s.alt2_op = 1'b0;
               raw_s.wb      = WB_ALU;
            end else begin
               raw_s.muldiv = 1'b0;
            end
         end
         default: known_s = 1'b0;
      endcase
   end

   // encodings outside the supported subset
   always_comb begin
      illegal_s = 1'b0;
      if (opcode_s[1:0] != 2'b11) begin
         illegal_s = 1'b1;
      end else if (!known_s) begin
         illegal_s = 1'b1;
      end else if (is_op_s && (funct7_s == F7_MULDIV)) begin
         illegal_s = !ENABLE_M;
      end else if (is_op_s && (funct7_s != F7_BASE) && (funct7_s != F7_ALT)) begin
         illegal_s = 1'b1;
      end else begin
         illegal_s = 1'b0;
      end
   end

   // illegal entries carry no side effects and no operand dependencies
   always_comb begin
      dec         = raw_s;
      dec.illegal = illegal_s;
      if (illegal_s) begin
         dec.wb       = WB_NONE;
         dec.mem      = 1'b0;
         dec.mem_read = 1'b0;
         dec.branch   = 1'b0;
         dec.muldiv   = 1'b0;
         dec.ra       = 5'd0;
         dec.rb       = 5'd0;
      end else if (rd_s == 5'd0) begin
         dec.wb = WB_NONE;
      end else begin
         dec.wb = raw_s.wb;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode feeding a small FIFO of decoded entries,
// with a load-use scoreboard that stalls consumers of in-flight load results.
module decode_stage
   import myrv_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter bit          ENABLE_M   = 1'b0,
   parameter bit          LOAD_STALL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic        load_done,
   input  logic [4:0]  load_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_alu_op,
   output logic [1:0]  out_alu2_op,
   output logic        out_alt_op,
   output logic        out_alt2_op,
   output logic [4:0]  out_ra,
   output logic [4:0]  out_rb,
   output logic [4:0]  out_rd,
   output logic        out_sel_pc_a,
   output logic        out_sel_imm_b,
   output logic [1:0]  out_wb,
   output logic        out_mem_read,
   output logic        out_mem,
   output logic        out_branch,
   output logic [2:0]  out_comparison,
   output logic        out_muldiv,
   output logic [2:0]  out_funct3,
   output logic        out_illegal
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   decoded_t      dec_s;
   decoded_t      head_s;
   decoded_t      fifo_mem [DEPTH];
   logic [PW-1:0] wptr_r;
   logic [PW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic [31:0]   sb_r;
   logic [31:0]   clr_mask_s;
   logic [31:0]   set_mask_s;
   logic [31:0]   sb_live_s;
   logic [31:0]   sb_next_s;
   logic          full_s;
   logic          hazard_s;
   logic          push_s;
   logic          pop_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (DEPTH == 1) begin
         ptr_inc = '0;
      end else begin
         ptr_inc = p + PW'(1);
      end
   endfunction

   rv_decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
      .instr (in_instr),
      .dec   (dec_s)
   );

   // a completing load releases its register in the same cycle (bypass); a new load to it wins
   always_comb begin
      clr_mask_s = 32'd0;
      set_mask_s = 32'd0;
      if (load_done) begin
         clr_mask_s = reg_mask(load_rd);
      end else begin
         clr_mask_s = 32'd0;
      end
      if (push_s && dec_s.mem && dec_s.mem_read && !dec_s.illegal && (dec_s.rd != 5'd0)) begin
         set_mask_s = reg_mask(dec_s.rd);
      end else begin
         set_mask_s = 32'd0;
      end
   end

   assign sb_live_s = sb_r & ~clr_mask_s;
   assign sb_next_s = (sb_live_s | set_mask_s) & 32'hFFFF_FFFE;
   assign hazard_s  = LOAD_STALL && in_valid &&
                      (((dec_s.ra != 5'd0) && sb_live_s[dec_s.ra]) ||
                       ((dec_s.rb != 5'd0) && sb_live_s[dec_s.rb]));
   // a full FIFO still accepts when the head leaves in the same cycle
   assign full_s    = (count_r == CW'(DEPTH)) && !out_ready;
   assign in_ready  = !full_s && !hazard_s && !flush;
   assign out_valid = (count_r != {CW{1'b0}});
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready && !flush;

   // occupancy, pointers and scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CW{1'b0}};
         wptr_r  <= {PW{1'b0}};
         rptr_r  <= {PW{1'b0}};
         sb_r    <= 32'd0;
      end else if (flush) begin
         count_r <= {CW{1'b0}};
         wptr_r  <= {PW{1'b0}};
         rptr_r  <= {PW{1'b0}};
         sb_r    <= 32'd0;
      end else begin
         sb_r   <= sb_next_s;
         wptr_r <= push_s ? ptr_inc(wptr_r) : wptr_r;
         rptr_r <= pop_s  ? ptr_inc(rptr_r) : rptr_r;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // payload storage, intentionally not reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem[wptr_r] <= dec_s;
      end
   end

   assign head_s         = fifo_mem[rptr_r];
   assign out_alu_op     = head_s.alu_op;
   assign out_alu2_op    = head_s.alu2_op;
   assign out_alt_op     = head_s.alt_op;
   assign out_alt2_op    = head_s.alt2_op;
   assign out_ra         = head_s.ra;
   assign out_rb         = head_s.rb;
   assign out_rd         = head_s.rd;
   assign out_sel_pc_a   = head_s.sel_pc_a;
   assign out_sel_imm_b  = head_s.sel_imm_b;
   assign out_wb         = head_s.wb;
   assign out_mem_read   = head_s.mem_read;
   assign out_mem        = head_s.mem;
   assign out_branch     = head_s.branch;
   assign out_comparison = head_s.comparison;
   assign out_muldiv     = head_s.muldiv;
   assign out_funct3     = head_s.funct3;
   assign out_illegal    = head_s.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DEPTH, default 2: decoded-entry FIFO depth; power of two, minimum 1.
REQ-002 Parameter ENABLE_M, default 0: 1 decodes RV32M as legal; 0 flags RV32M as illegal.
REQ-003 Parameter LOAD_STALL, default 1: 1 enables the load-use scoreboard; 0 means never stall.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  discards all queued entries and clears the scoreboard.
REQ-007 in_valid  in  1  in_instr is valid.
REQ-008 in_ready  out  1  stage accepts in_instr this cycle.
REQ-009 in_instr  in  32  raw RV32I instruction word.
REQ-010 load_done  in  1  a previously issued load has written back.
REQ-011 load_rd  in  5  destination register of the completing load.
REQ-012 out_valid  out  1  head entry is valid.
REQ-013 out_ready  in  1  consumer takes the head entry.
REQ-014 out_alu_op 2, out_alu2_op 2, out_alt_op 1, out_alt2_op 1, out_ra 5, out_rb 5, out_rd 5, out_sel_pc_a 1, out_sel_imm_b 1, out_wb 2, out_mem_read 1, out_mem 1, out_branch 1, out_comparison 3  out  decoded control fields of the head entry.
REQ-015 out_muldiv  out  1  head entry is an RV32M op; out_funct3 selects the op.
REQ-016 out_funct3  out  3  raw funct3 of the head entry.
REQ-017 out_illegal  out  1  head entry is an illegal encoding.

Function
REQ-018 Field encodings SHALL be: alu_op 0 ADD, 1 AND, 2 XOR, 3 OR; alu2_op 0 SHL/ADD-path, 1 SLT/compare, 2 SHR, 3 pass-immediate; wb 0 none, 1 link, 2 ALU, 3 ALU2/LUI. Any write with rd=0 SHALL force wb=0.
REQ-019 Decode SHALL be purely combinational on in_instr; the result is enqueued on in_valid && in_ready.
REQ-020 Latency SHALL be 1 cycle: an instruction accepted at cycle N into an empty FIFO presents out_valid at N+1.
REQ-021 in_ready SHALL be !full && !hazard && !flush.
REQ-022 hazard SHALL be LOAD_STALL && in_valid && ((ra!=0 && sb[ra]) || (rb!=0 && sb[rb])). In-flight load destinations SHALL be tracked in sb[31:1].
REQ-023 sb[rd] SHALL be set when a load with rd!=0 is enqueued (mem && mem_read && !illegal).
REQ-024 load_done SHALL clear sb[load_rd]. If a set and a clear hit the same register in the same cycle, the set SHALL win.
REQ-025 If load_done clears a register that the stalled in_instr is waiting on, in_ready SHALL rise in the same cycle (bypass).
REQ-026 The FIFO SHALL allow enqueue and dequeue in the same cycle when full; occupancy then stays DEPTH.
REQ-027 Pointers SHALL wrap modulo DEPTH. Occupancy SHALL be a counter of clog2(DEPTH)+1 bits.
REQ-028 Illegal SHALL be: opcode[1:0]!=2'b11; opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}; funct7 not 0/0x20 on OP; or funct7=0x01 with ENABLE_M=0.
REQ-029 Illegal entries SHALL be enqueued with illegal=1 and wb=0, mem=0, branch=0.
REQ-030 With ENABLE_M=1, an OP with funct7=0x01 SHALL give muldiv=1, wb=2, alt_op=0.
REQ-031 flush SHALL empty the FIFO and clear all sb bits on the next edge. Any in_valid presented that cycle SHALL be dropped. flush SHALL take priority over all other events.
REQ-032 out_* fields SHALL be don't-care while out_valid=0. They SHALL be stable while out_valid && !out_ready.

Reset
REQ-033 rst_n low SHALL asynchronously clear the occupancy counter, the pointers and sb. out_valid is then 0 and in_ready is 1 (once released).
REQ-034 FIFO payload storage SHALL NOT be reset.
REQ-035 Reset deasserted mid-stall SHALL resume with an empty FIFO and no hazard.

Structure
REQ-036 The alu_op, alu2_op and wb enums, the opcode constants and the funct7 constants SHALL live in myrv_pkg.
REQ-037 The combinational decode SHALL be one sub-module, rv_decode_comb. It takes the ENABLE_M parameter and outputs a packed struct defined in myrv_pkg.

Verification
REQ-038 Cover: ADDI x1,x0,5 with out_ready=1 -> out_valid at +1 cycle, alu_op=0, wb=2, sel_imm_b=1, illegal=0.
REQ-039 Cover: LW x5, then ADD x6,x5,x1 back-to-back -> in_ready=0 until load_done with load_rd=5; the ADD is accepted in the load_done cycle.
REQ-040 Cover: DEPTH=2, out_ready=0, 3 instructions offered -> 2 accepted, in_ready=0. Then out_ready=1 with in_valid=1 -> one in and one out per cycle, occupancy stays 2.
REQ-041 Cover: MUL x3,x1,x2 with ENABLE_M=0 -> illegal=1, wb=0. With ENABLE_M=1 -> muldiv=1, wb=2.
REQ-042 Cover: flush with 2 queued entries and sb[5]=1 -> next cycle out_valid=0, ADD x6,x5,x1 accepted immediately.
REQ-043 Cover: rst_n pulsed low mid-stream with the FIFO full -> out_valid=0 within the same cycle, in_ready=1 after release.
